// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, line
// geometry and the Sysbus read-from-memory request tag.
package fetch_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StIdle    = 3'd0;
  localparam state_t StReq     = 3'd1;
  localparam state_t StResp    = 3'd2;
  localparam state_t StDeliver = 3'd3;
  localparam state_t StDrain   = 3'd4;
  localparam state_t StHalt    = 3'd5;

  localparam int unsigned LINE_BYTES    = 64;
  localparam int unsigned LINE_WORDS    = 16;
  localparam int unsigned WORD_IDX_BITS = 4;

  // Sysbus tag fields: {read/write, target device, 8 spare bits}.
  localparam logic       SYSBUS_READ   = 1'b1;
  localparam logic [3:0] SYSBUS_MEMORY = 4'b0001;
  localparam logic [12:0] READ_TAG     = {SYSBUS_READ, SYSBUS_MEMORY, 8'h00};

  // Clear the byte-within-line bits of an address.
  function automatic logic [63:0] line_addr(input logic [63:0] addr);
    return addr & ~64'(LINE_BYTES - 1);
  endfunction

endpackage

// File: rtl/fetch_line_buffer.sv
// One instruction line: 16 x 32-bit words, filled a 64-bit beat at a time and
// read one word at a time through an asynchronous index.
module fetch_line_buffer
  import fetch_pkg::*;
(
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [2:0]               wr_beat,
  input  logic [63:0]              wr_data,
  input  logic [WORD_IDX_BITS-1:0] rd_idx,
  output logic [31:0]              rd_data
);

  logic [31:0] mem [LINE_WORDS];

  // Beat k fills words 2k (low half) and 2k+1 (high half).
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{wr_beat, 1'b0}] <= wr_data[31:0];
      mem[{wr_beat, 1'b1}] <= wr_data[63:32];
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: requests 64-byte lines over Sysbus, buffers them and
// hands instructions to the decoder in program order with valid/ready.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned BUS_DATA_WIDTH = 64,
  parameter int unsigned BUS_TAG_WIDTH  = 13,
  parameter int unsigned LINE_BEATS     = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [63:0]               entry,
  input  logic                      redirect_valid,
  input  logic [63:0]               redirect_pc,
  output logic                      bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic                      bus_respack,
  output logic                      instr_valid,
  output logic [31:0]               instruction,
  output logic [63:0]               instr_pc,
  input  logic                      instr_ready,
  output logic                      halted
);

  localparam int unsigned BeatBits = $clog2(LINE_BEATS);
  localparam logic [BeatBits-1:0] LastBeat = BeatBits'(LINE_BEATS - 1);

  state_t              state_q, fsm_state, state_d;
  logic [63:0]         pc_q, pc_d;
  logic [BeatBits-1:0] cnt_q, cnt_d;
  logic                discard_q, discard_d;
  logic                beat_we, last_beat;
  logic [63:0]         redir_pc;
  logic [31:0]         buf_rdata, word_d;

  logic unused_inputs;
  assign unused_inputs = ^{bus_resptag, redirect_pc[1:0]};

  assign redir_pc  = {redirect_pc[63:2], 2'b00};
  assign last_beat = bus_respcyc && (cnt_q == LastBeat);

  fetch_line_buffer u_line_buffer (
    .clk     (clk),
    .wr_en   (beat_we),
    .wr_beat (cnt_q),
    .wr_data (bus_resp),
    .rd_idx  (pc_d[5:2]),
    .rd_data (buf_rdata)
  );

  // Next-state, pc and beat-count logic; redirects override any pc advance.
  always_comb begin
    fsm_state   = state_q;
    pc_d        = pc_q;
    cnt_d       = cnt_q;
    discard_d   = discard_q;
    bus_respack = 1'b0;
    beat_we     = 1'b0;
    unique case (state_q)
      StIdle: begin
        pc_d      = entry;
        fsm_state = StReq;
      end
      StReq: begin
        if (redirect_valid) pc_d = redir_pc;
        if (bus_reqack) begin
          // A redirected request is still answered; its line must be drained.
          fsm_state = (discard_q || redirect_valid) ? StDrain : StResp;
          discard_d = 1'b0;
        end else if (redirect_valid) begin
          discard_d = 1'b1;
        end
      end
      StResp: begin
        bus_respack = bus_respcyc;
        beat_we     = bus_respcyc;
        if (bus_respcyc) cnt_d = last_beat ? '0 : cnt_q + 1'b1;
        if (redirect_valid) begin
          pc_d      = redir_pc;
          fsm_state = last_beat ? StReq : StDrain;
        end else if (last_beat) begin
          fsm_state = StDeliver;
        end
      end
      StDeliver: begin
        if (redirect_valid) begin
          pc_d      = redir_pc;
          fsm_state = StReq;
        end else if (instr_valid && instr_ready) begin
          pc_d = pc_q + 64'd4;
          if (pc_q[5:2] == 4'hf) fsm_state = StReq;
        end
      end
      StDrain: begin
        bus_respack = bus_respcyc;
        if (bus_respcyc) cnt_d = last_beat ? '0 : cnt_q + 1'b1;
        if (redirect_valid) pc_d = redir_pc;
        if (last_beat) fsm_state = StReq;
      end
      StHalt: begin
        fsm_state = StHalt;
      end
      default: begin
        fsm_state = StIdle;
      end
    endcase
  end

  // Word about to be presented; bypass the beat being written this cycle.
  always_comb begin
    word_d = buf_rdata;
    if (beat_we && (cnt_q == pc_d[5:3])) begin
      word_d = pc_d[2] ? bus_resp[63:32] : bus_resp[31:0];
    end
    state_d = fsm_state;
    if (fsm_state == StDeliver && word_d == 32'h0) state_d = StHalt;
  end

  // Core state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      cnt_q     <= '0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      discard_q <= discard_d;
    end
  end

  // Registered outputs, computed from the next state so they line up with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_reqcyc  <= 1'b0;
      bus_req     <= '0;
      bus_reqtag  <= '0;
      instr_valid <= 1'b0;
      instruction <= '0;
      instr_pc    <= '0;
      halted      <= 1'b0;
    end else begin
      bus_reqcyc <= (state_d == StReq);
      bus_reqtag <= (state_d == StReq) ? BUS_TAG_WIDTH'(READ_TAG) : '0;
      // Address is captured on entry to REQ and held until acked.
      if (state_q != StReq && state_d == StReq) bus_req <= line_addr(pc_d);
      instr_valid <= (state_d == StDeliver);
      if (state_d == StDeliver) begin
        instruction <= word_d;
        instr_pc    <= pc_d;
      end
      halted <= (state_d == StHalt);
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: random-latency memory responder, a
// delivery monitor and directed scenarios checked against a program-order model.
module tb_instr_fetch;

  localparam logic [63:0] NoZero = 64'hffff_ffff_ffff_ffff;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] entry;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        bus_reqcyc;
  logic [63:0] bus_req;
  logic [12:0] bus_reqtag;
  logic        bus_reqack;
  logic        bus_respcyc;
  logic [63:0] bus_resp;
  logic [12:0] bus_resptag;
  logic        bus_respack;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [63:0] instr_pc;
  logic        instr_ready;
  logic        halted;

  instr_fetch dut (
    .clk            (clk),
    .reset          (reset),
    .entry          (entry),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus_reqcyc     (bus_reqcyc),
    .bus_req        (bus_req),
    .bus_reqtag     (bus_reqtag),
    .bus_reqack     (bus_reqack),
    .bus_respcyc    (bus_respcyc),
    .bus_resp       (bus_resp),
    .bus_resptag    (bus_resptag),
    .bus_respack    (bus_respack),
    .instr_valid    (instr_valid),
    .instruction    (instruction),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] ins;
    int          cyc;
  } deliv_t;

  deliv_t      got[$];
  logic [63:0] req_q[$];
  int          line_end_q[$];
  logic [63:0] zero_addr = NoZero;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Memory image: word at address a is 0x13 + (a - 0x1000)/4, one optional hole.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == zero_addr) return 32'h0;
    return 32'h13 + 32'((a - 64'h1000) >> 2);
  endfunction

  // Memory responder: random ack latency, LINE_BEATS beats with random gaps.
  int          rsp_phase = 0;
  int          rsp_beat  = 0;
  int          ack_wait  = 0;
  int          gap       = 0;
  logic [63:0] rsp_addr  = '0;
  initial begin
    bus_reqack  = 1'b0;
    bus_respcyc = 1'b0;
    bus_resp    = '0;
    bus_resptag = '0;
    forever begin
      @(negedge clk);
      bus_reqack  = 1'b0;
      bus_respcyc = 1'b0;
      if (reset) begin
        rsp_phase = 0;
        rsp_beat  = 0;
      end else begin
        if (rsp_phase == 0 && bus_reqcyc) begin
          ack_wait  = $urandom_range(0, 2);
          rsp_phase = 1;
        end
        if (rsp_phase == 1) begin
          if (ack_wait == 0) begin
            bus_reqack = 1'b1;
            req_q.push_back(bus_req);
            check("req_tag", 64'(bus_reqtag), 64'h1100);
            rsp_addr  = bus_req;
            rsp_beat  = 0;
            gap       = $urandom_range(0, 1);
            rsp_phase = 2;
          end else begin
            ack_wait--;
          end
        end else if (rsp_phase == 2) begin
          if (gap != 0) begin
            gap--;
          end else begin
            bus_respcyc = 1'b1;
            bus_resptag = 13'h1100;
            bus_resp    = {mem_word(rsp_addr + 64'(rsp_beat * 8 + 4)),
                           mem_word(rsp_addr + 64'(rsp_beat * 8))};
            rsp_beat++;
            if (rsp_beat == 8) begin
              rsp_phase = 0;
              line_end_q.push_back(cyc);
            end
            gap = $urandom_range(0, 1);
            #1;
            check("beat_ack", 64'(bus_respack), 64'd1);
          end
        end
      end
    end
  end

  // Delivery monitor: logs handshakes and checks hold-stability under stall.
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic        prev_redir = 1'b0;
  logic [31:0] prev_ins   = '0;
  logic [63:0] prev_pc    = '0;
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        prev_valid = 1'b0;
      end else begin
        if (prev_valid && !prev_ready && !prev_redir) begin
          check("stall_valid", 64'(instr_valid), 64'd1);
          check("stall_ins", 64'(instruction), 64'(prev_ins));
          check("stall_pc", instr_pc, prev_pc);
        end
        if (instr_valid && instr_ready) got.push_back('{instr_pc, instruction, cyc});
        prev_valid = instr_valid;
        prev_ready = instr_ready;
        prev_redir = redirect_valid;
        prev_ins   = instruction;
        prev_pc    = instr_pc;
      end
    end
  end

  task automatic check_zero_outputs(input string tag);
    check({tag, "_reqcyc"}, 64'(bus_reqcyc), 64'd0);
    check({tag, "_req"}, bus_req, 64'd0);
    check({tag, "_reqtag"}, 64'(bus_reqtag), 64'd0);
    check({tag, "_respack"}, 64'(bus_respack), 64'd0);
    check({tag, "_valid"}, 64'(instr_valid), 64'd0);
    check({tag, "_ins"}, 64'(instruction), 64'd0);
    check({tag, "_pc"}, instr_pc, 64'd0);
    check({tag, "_halted"}, 64'(halted), 64'd0);
  endtask

  task automatic do_reset(input logic [63:0] e, input logic [63:0] zaddr);
    @(negedge clk);
    #3;
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b1;
    entry          = e;
    zero_addr      = zaddr;
    #1;
    check_zero_outputs("rst");
    repeat (2) @(negedge clk);
    got.delete();
    req_q.delete();
    line_end_q.delete();
    #1;
    reset = 1'b0;
    #1;
    check("cycle0_reqcyc", 64'(bus_reqcyc), 64'd0);
    @(negedge clk);
    #2;
    check("cycle1_reqcyc", 64'(bus_reqcyc), 64'd1);
  endtask

  task automatic wait_got(input int n, input string tag);
    int k = 0;
    while (got.size() < n && k < 2000) begin
      @(negedge clk);
      #3;
      k++;
    end
    check({tag, "_got_timeout"}, 64'(got.size() >= n), 64'd1);
  endtask

  task automatic wait_req(input int n, input string tag);
    int k = 0;
    while (req_q.size() < n && k < 2000) begin
      @(negedge clk);
      #3;
      k++;
    end
    check({tag, "_req_timeout"}, 64'(req_q.size() >= n), 64'd1);
  endtask

  task automatic wait_resp_beats(input int n, output logic found);
    int k = 0;
    found = 1'b0;
    while (!found && k < 2000) begin
      @(negedge clk);
      #1;
      if (rsp_phase == 2 && rsp_beat >= n) found = 1'b1;
      else k++;
    end
  endtask

  initial begin
    logic        found;
    logic [3:0]  pat;
    int          k;
    int          n;
    int          dup;
    logic [63:0] exp_pc;

    reset          = 1'b1;
    entry          = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b1;

    // Straight line from 0x1000.
    do_reset(64'h1000, NoZero);
    wait_got(16, "t1");
    wait_req(2, "t1");
    check("t1_req0", req_q[0], 64'h1000);
    check("t1_req1", req_q[1], 64'h1040);
    check("t1_first_latency", 64'(got[0].cyc), 64'(line_end_q[0] + 1));
    for (int i = 0; i < 16; i++) begin
      exp_pc = 64'h1000 + 64'(4 * i);
      check("t1_pc", got[i].pc, exp_pc);
      check("t1_ins", 64'(got[i].ins), 64'(mem_word(exp_pc)));
      check("t1_rate", 64'(got[i].cyc - got[0].cyc), 64'(i));
    end

    // Unaligned entry near the end of a line.
    do_reset(64'h1038, NoZero);
    wait_got(3, "t2");
    check("t2_req0", req_q[0], 64'h1000);
    check("t2_req1", req_q[1], 64'h1040);
    check("t2_pc0", got[0].pc, 64'h1038);
    check("t2_pc1", got[1].pc, 64'h103c);
    check("t2_pc2", got[2].pc, 64'h1040);
    check("t2_ins2", 64'(got[2].ins), 64'(mem_word(64'h1040)));

    // Backpressure: 1,0,0,1 then random ready across a line crossing.
    do_reset(64'h1000, NoZero);
    pat = 4'b1001;
    k   = 0;
    n   = 0;
    while (got.size() < 20 && k < 3000) begin
      @(negedge clk);
      #1;
      if (instr_valid) begin
        instr_ready = (n < 4) ? pat[n] : 1'($urandom_range(0, 1));
        n++;
      end
      k++;
    end
    instr_ready = 1'b1;
    check("t3_got_timeout", 64'(got.size() >= 20), 64'd1);
    for (int i = 0; i < 20; i++) begin
      exp_pc = 64'h1000 + 64'(4 * i);
      check("t3_pc", got[i].pc, exp_pc);
      check("t3_ins", 64'(got[i].ins), 64'(mem_word(exp_pc)));
    end

    // Redirect while the line is still arriving.
    do_reset(64'h1000, NoZero);
    wait_resp_beats(4, found);
    check("t4_in_resp", 64'(found), 64'd1);
    redirect_pc    = 64'h2006;
    redirect_valid = 1'b1;
    @(negedge clk);
    #1;
    redirect_valid = 1'b0;
    wait_req(2, "t4");
    wait_got(2, "t4");
    check("t4_req1", req_q[1], 64'h2000);
    check("t4_pc0", got[0].pc, 64'h2004);
    check("t4_ins0", 64'(got[0].ins), 64'(mem_word(64'h2004)));
    check("t4_pc1", got[1].pc, 64'h2008);

    // Handshake and redirect in the same cycle.
    do_reset(64'h1000, NoZero);
    k     = 0;
    found = 1'b0;
    while (!found && k < 2000) begin
      @(negedge clk);
      #1;
      if (instr_valid && instr_pc == 64'h1008) found = 1'b1;
      else k++;
    end
    check("t5_seen_1008", 64'(found), 64'd1);
    redirect_pc    = 64'h3000;
    redirect_valid = 1'b1;
    @(negedge clk);
    #1;
    redirect_valid = 1'b0;
    check("t5_valid_drop", 64'(instr_valid), 64'd0);
    wait_req(2, "t5");
    wait_got(4, "t5");
    check("t5_req1", req_q[1], 64'h3000);
    check("t5_pc2", got[2].pc, 64'h1008);
    check("t5_pc3", got[3].pc, 64'h3000);
    dup = 0;
    foreach (got[i]) if (got[i].pc == 64'h100c || got[i].pc == 64'h1008) dup++;
    check("t5_1008_once", 64'(dup), 64'd1);

    // Zero word halts the fetch.
    do_reset(64'h1000, 64'h1010);
    k = 0;
    while (!halted && k < 2000) begin
      @(negedge clk);
      #3;
      k++;
    end
    check("t6_halted", 64'(halted), 64'd1);
    check("t6_count", 64'(got.size()), 64'd4);
    for (int i = 0; i < 4; i++) check("t6_pc", got[i].pc, 64'h1000 + 64'(4 * i));
    repeat (5) begin
      @(negedge clk);
      #3;
      check("t6_stay_invalid", 64'(instr_valid), 64'd0);
      check("t6_stay_halted", 64'(halted), 64'd1);
      check("t6_no_req", 64'(bus_reqcyc), 64'd0);
    end

    // Asynchronous reset in the middle of a line.
    do_reset(64'h1000, NoZero);
    wait_resp_beats(2, found);
    check("t7_in_resp", 64'(found), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check_zero_outputs("t7_async");
    repeat (2) @(negedge clk);
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
